uart_tx_slave: RTL and testbench
================================

Name: uart_tx_slave

Overview:
- Memory-mapped UART transmitter.
- Acts as a responder on the core's memory-map slave bus (data/address/write-select/read-select from the master memory map).
- Buffers bytes written by the core in a small FIFO and serialises them 8N1 on the tx pin.
- Gives the core a buffered, pollable console output path alongside RAM.

Parameters:
- DATA_WIDTH, 32, bus data width.
- CLK_FREQ, 50000000, system clock in Hz.
- BAUD, 115200, reset baud rate.
- FIFO_DEPTH, 8, TX FIFO entries; power of 2, at least 2.
- DIV_RESET, CLK_FREQ/BAUD (434), reset value of the baud divisor.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- wd  input  DATA_WIDTH  write data from the memory map.
- address  input  32  slave-relative address; only address[3:2] is decoded.
- we  input  1  write select; one write per cycle.
- re  input  1  read select.
- rd  output  DATA_WIDTH  read data, combinational.
- tx  output  1  serial line, registered, idle high.
- irq_empty  output  1  high while FIFO empty and FSM idle.

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n).
  - Reset values: tx=1, irq_empty=1, FIFO empty, FSM=IDLE, divisor=DIV_RESET, overflow=0.
  - rd is 0 whenever re=0.
- Register map (address[3:2]):
  - 0 TXDATA (W): we pushes wd[7:0]. Reads return 0.
  - 1 STATUS (R/W1C): bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits[7:4] FIFO count. Writing wd[3]=1 clears overflow.
  - 2 BAUD_DIV (R/W): bits[15:0] are clock cycles per bit. Written values below 2 are stored as 2.
  - 3 reserved: reads 0, writes ignored.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START: when the FIFO is non-empty, pop into the shift register, set tx=0, load the bit counter with the divisor.
  - START -> DATA: after divisor cycles.
  - DATA: shift LSB first, 8 bits, each lasting divisor cycles.
  - DATA -> STOP: after the 8th bit. STOP drives tx=1 for divisor cycles.
  - STOP -> START directly if the FIFO is non-empty (back-to-back frames, no idle gap); otherwise STOP -> IDLE.
- Latency: a write to an empty FIFO with the FSM idle makes tx fall on the second rising edge after the write edge (push edge, then pop/START edge).
- Frame length is exactly 10*divisor cycles.
- A divisor change takes effect at the next bit boundary; the current bit completes with the old value.
- FIFO full + TXDATA write: data dropped, overflow set, count unchanged.
- Pop in the same cycle as a push into a full FIFO: push accepted (count stays FIFO_DEPTH), overflow not set.
- Pointers wrap modulo FIFO_DEPTH. Count is $clog2(FIFO_DEPTH)+1 bits, zero-extended into STATUS[7:4].
- Reset asserted mid-frame: tx returns high immediately (asynchronously); queued data is discarded.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP, driving even parity of the 8 data bits for divisor cycles. Frame length becomes 11*divisor. STATUS bit8 reads 1 (parity present).
- Undefined: 8N1 only. STATUS bit8 reads 0.

Decomposition:
- Package uart_tx_pkg holds:
  - register offsets (REG_TXDATA=2'd0, REG_STATUS=2'd1, REG_BAUD=2'd2);
  - STATUS bit positions;
  - the FSM state encoding;
  - the minimum divisor constant (2).
- One sub-module: sync_fifo_param.
  - Parameters: WIDTH=8, DEPTH=FIFO_DEPTH.
  - Ports: push, pop, din, dout, full, empty, count.
  - Same clk/rst_n.
- The FSM, baud counter and register decode stay in uart_tx_slave.

Test Plan:
- Reset then read STATUS -> rd=0x04 (empty), tx=1, BAUD_DIV reads 434.
- Write BAUD_DIV=4, then TXDATA=0x55 -> tx sequence 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles, start on the 2nd edge after the write. irq_empty returns to 1 after 40 cycles.
- Write BAUD_DIV=0 -> readback 2. Write 0xA3 -> frame of 20 cycles decodes to 0xA3.
- Write 9 bytes back-to-back with FIFO_DEPTH=8 and divisor 100 -> first byte popped; the remaining writes fill the FIFO; no overflow. A 10th write -> overflow=1, STATUS bits[7:4]=8. Write STATUS wd=0x8 -> overflow=0. All 9 frames emitted contiguously with no idle gap.
- Assert rst_n low in DATA bit 3 -> tx=1 asynchronously, STATUS=0x04 after release, no residual frame.
- With UART_TX_PARITY_EN, divisor 4, send 0x07 -> parity bit 1, frame 44 cycles. Send 0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Holds the register offsets, the STATUS bit layout, the FSM state encoding
// and the minimum baud divisor.
package uart_tx_pkg;

  // Register offsets, decoded from address[3:2]
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_BAUD   = 2'd2;

  // STATUS bit positions
  localparam int unsigned ST_BUSY_BIT  = 0;
  localparam int unsigned ST_FULL_BIT  = 1;
  localparam int unsigned ST_EMPTY_BIT = 2;
  localparam int unsigned ST_OVF_BIT   = 3;
  localparam int unsigned ST_CNT_LSB   = 4;
  localparam int unsigned ST_CNT_W     = 4;
  localparam int unsigned ST_PAR_BIT   = 8;

  // Baud divisor width and the smallest divisor that is ever stored
  localparam int unsigned DIV_W   = 16;
  localparam logic [15:0] MIN_DIV = 16'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx_slave_fifo.sv
// Synchronous FIFO used as the UART transmit buffer.
// Ports: clk, rst_n, push/din (write), pop/dout (read, dout shows the head
// entry), full, empty, count (number of stored entries).
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; otherwise it is ignored. Pointers wrap modulo DEPTH (power of 2).
module sync_fifo_param #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rd];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= din;
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + AW'(1);
      if (w_do_pop)  r_rd <= r_rd + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_slave.sv
// Memory-mapped UART transmitter (8N1, optional even parity).
// Ports: clk, rst_n (async active-low); wd/address/we/re/rd memory-map slave
// bus (rd combinational, 0 when re=0); tx serial line (registered, idle high);
// irq_empty high while the FIFO is empty and the FSM is idle.
// Registers (address[3:2]): 0 TXDATA (W), 1 STATUS (R/W1C overflow),
// 2 BAUD_DIV (R/W, min 2), 3 reserved.
// Build option: define UART_TX_PARITY_EN to append an even parity bit.
module uart_tx_slave
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_RESET  = CLK_FREQ / BAUD
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic [31:0]           address,
  input  logic                  we,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] rd,
  output logic                  tx,
  output logic                  irq_empty
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e        r_state;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_cnt;
  logic [7:0]       r_shift;
  logic [2:0]       r_bit;
  logic             r_tx;
  logic             r_ovf;
`ifdef UART_TX_PARITY_EN
  logic             r_par;
`endif

  logic [1:0]            w_reg;
  logic                  w_wr_tx;
  logic                  w_pop;
  logic                  w_tick;
  logic                  w_full;
  logic                  w_empty;
  logic [7:0]            w_dout;
  logic [CW-1:0]         w_count;
  logic [DATA_WIDTH-1:0] w_status;
  logic                  w_unused_bits;

  assign w_reg   = address[3:2];
  assign w_wr_tx = we && (w_reg == REG_TXDATA);
  assign w_tick  = (r_cnt == DIV_W'(1));
  // Pop when idle, or at the end of a stop bit to chain frames without a gap
  assign w_pop   = !w_empty && ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_tick));
  assign w_unused_bits = ^{address[31:4], address[1:0], wd[DATA_WIDTH-1:16]};

  sync_fifo_param #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_wr_tx),
    .pop   (w_pop),
    .din   (wd[7:0]),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // Divisor register and sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= 16'(DIV_RESET);
      r_ovf <= 1'b0;
    end else begin
      if (we && (w_reg == REG_BAUD))
        r_div <= (wd[15:0] < MIN_DIV) ? MIN_DIV : wd[15:0];
      // A same-cycle pop frees a slot, so that push is not an overflow
      if (w_wr_tx && w_full && !w_pop)
        r_ovf <= 1'b1;
      else if (we && (w_reg == REG_STATUS) && wd[ST_OVF_BIT])
        r_ovf <= 1'b0;
    end
  end

  // Transmit FSM; the bit counter reloads from r_div at every bit boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_tx    <= 1'b1;
      r_cnt   <= '0;
      r_shift <= '0;
      r_bit   <= '0;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_state <= ST_START;
            r_tx    <= 1'b0;
            r_cnt   <= r_div;
            r_shift <= w_dout;
`ifdef UART_TX_PARITY_EN
            r_par   <= ^w_dout;
`endif
          end
        end
        ST_START: begin
          if (w_tick) begin
            r_state <= ST_DATA;
            r_tx    <= r_shift[0];
            r_cnt   <= r_div;
            r_bit   <= '0;
          end else begin
            r_cnt <= r_cnt - DIV_W'(1);
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            r_cnt <= r_div;
            if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_state <= ST_PARITY;
              r_tx    <= r_par;
`else
              r_state <= ST_STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt - DIV_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (w_tick) begin
            r_state <= ST_STOP;
            r_tx    <= 1'b1;
            r_cnt   <= r_div;
          end else begin
            r_cnt <= r_cnt - DIV_W'(1);
          end
        end
`endif
        ST_STOP: begin
          if (w_tick) begin
            if (w_pop) begin
              r_state <= ST_START;
              r_tx    <= 1'b0;
              r_cnt   <= r_div;
              r_shift <= w_dout;
`ifdef UART_TX_PARITY_EN
              r_par   <= ^w_dout;
`endif
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - DIV_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  // STATUS word
  always_comb begin
    w_status = '0;
    w_status[ST_BUSY_BIT]  = (r_state != ST_IDLE);
    w_status[ST_FULL_BIT]  = w_full;
    w_status[ST_EMPTY_BIT] = w_empty;
    w_status[ST_OVF_BIT]   = r_ovf;
    w_status[ST_CNT_LSB +: ST_CNT_W] = ST_CNT_W'(w_count);
`ifdef UART_TX_PARITY_EN
    w_status[ST_PAR_BIT]   = 1'b1;
`endif
  end

  // Read mux
  always_comb begin
    rd = '0;
    if (re) begin
      case (w_reg)
        REG_STATUS: rd = w_status;
        REG_BAUD:   rd = DATA_WIDTH'(r_div);
        default:    rd = '0;
      endcase
    end
  end

  assign tx        = r_tx;
  assign irq_empty = w_empty && (r_state == ST_IDLE);

endmodule

// File: tb/tb_uart_tx_slave.sv
// Directed self-checking bench for uart_tx_slave.
module tb_uart_tx_slave;

`ifdef UART_TX_PARITY_EN
  localparam int unsigned NBITS  = 11;
  localparam logic [31:0] ST_PAR = 32'h100;
`else
  localparam int unsigned NBITS  = 10;
  localparam logic [31:0] ST_PAR = 32'h0;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] wd;
  logic [31:0] address;
  logic        we;
  logic        re;
  logic [31:0] rd;
  logic        tx;
  logic        irq_empty;

  int n_total;
  int n_bad;

  uart_tx_slave dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wd        (wd),
    .address   (address),
    .we        (we),
    .re        (re),
    .rd        (rd),
    .tx        (tx),
    .irq_empty (irq_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    we = 1'b1; address = addr; wd = data;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    re = 1'b1; address = addr;
    #1 data = rd;
    re = 1'b0;
  endtask

  // Returns at the first negedge where tx is low, bounded by max_cycles
  task automatic wait_tx_low(input int max_cycles);
    int n;
    n = 0;
    while (tx !== 1'b0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check_eq("tx_fall_wait", 32'(tx), 32'd0);
  endtask

  // Called at the negedge right after the start edge; samples every cycle
  task automatic rx_frame(input int div, input logic [7:0] exp_byte);
    logic [10:0] bits;
    int          errs;
    bits = '0;
    errs = 0;
    for (int b = 0; b < int'(NBITS); b++) begin
      for (int j = 0; j < div; j++) begin
        if (j == 0) bits[b] = tx;
        else if (tx !== bits[b]) errs++;
        @(negedge clk);
      end
    end
    check_eq("frm_start", 32'(bits[0]), 32'd0);
    check_eq("frm_data", 32'(bits[8:1]), 32'(exp_byte));
`ifdef UART_TX_PARITY_EN
    check_eq("frm_parity", 32'(bits[9]), 32'(^exp_byte));
`endif
    check_eq("frm_stop", 32'(bits[NBITS-1]), 32'd1);
    check_eq("frm_bit_len", 32'(errs), 32'd0);
  endtask

  logic [31:0] r;
  logic [7:0]  bytes9 [9];
  int          lows;

  initial begin
    n_total = 0; n_bad = 0;
    rst_n = 1'b0; we = 1'b0; re = 1'b0; wd = '0; address = '0;
    bytes9[0] = 8'h11; bytes9[1] = 8'h22; bytes9[2] = 8'h5A; bytes9[3] = 8'hC3;
    bytes9[4] = 8'h00; bytes9[5] = 8'hFF; bytes9[6] = 8'h81; bytes9[7] = 8'h7E;
    bytes9[8] = 8'h96;
    repeat (3) @(negedge clk);
    check_eq("rst_tx", 32'(tx), 32'd1);
    rst_n = 1'b1;

    // Reset state
    bus_read(32'h4, r);  check_eq("rst_status", r, 32'h04 | ST_PAR);
    check_eq("rst_irq", 32'(irq_empty), 32'd1);
    bus_read(32'h8, r);  check_eq("rst_baud", r, 32'd434);
    bus_read(32'h0, r);  check_eq("txdata_rd", r, 32'd0);
    bus_read(32'hC, r);  check_eq("resv_rd", r, 32'd0);
    address = 32'h4; #1 check_eq("rd_no_re", rd, 32'd0);

    // 0x55 at divisor 4, exact start latency
    bus_write(32'h8, 32'd4);
    bus_read(32'h8, r);  check_eq("baud_4", r, 32'd4);
    bus_write(32'h0, 32'h55);
    check_eq("lat_edge1_tx", 32'(tx), 32'd1);
    check_eq("lat_irq_low", 32'(irq_empty), 32'd0);
    @(negedge clk);
    check_eq("lat_edge2_tx", 32'(tx), 32'd0);
    rx_frame(4, 8'h55);
    check_eq("f55_idle_tx", 32'(tx), 32'd1);
    check_eq("f55_irq", 32'(irq_empty), 32'd1);

    // Divisor clamp to 2
    bus_write(32'h8, 32'd0);
    bus_read(32'h8, r);  check_eq("baud_clamp0", r, 32'd2);
    bus_write(32'h8, 32'd1);
    bus_read(32'h8, r);  check_eq("baud_clamp1", r, 32'd2);
    bus_write(32'h0, 32'hA3);
    wait_tx_low(10);
    rx_frame(2, 8'hA3);
    check_eq("fa3_irq", 32'(irq_empty), 32'd1);

    // FIFO fill, overflow and contiguous frames at divisor 100
    bus_write(32'h8, 32'd100);
    fork
      begin
        for (int i = 0; i < 9; i++) bus_write(32'h0, 32'(bytes9[i]));
        bus_read(32'h4, r);  check_eq("fill_status", r, 32'h83 | ST_PAR);
        bus_write(32'h0, 32'hEE);
        bus_read(32'h4, r);  check_eq("ovf_status", r, 32'h8B | ST_PAR);
        bus_write(32'h4, 32'h8);
        bus_read(32'h4, r);  check_eq("ovf_clear", r, 32'h83 | ST_PAR);
      end
      begin
        wait_tx_low(20);
        for (int i = 0; i < 9; i++) rx_frame(100, bytes9[i]);
        check_eq("b2b_idle_tx", 32'(tx), 32'd1);
        check_eq("b2b_irq", 32'(irq_empty), 32'd1);
      end
    join

    // Reset during data bit 3
    bus_write(32'h8, 32'd4);
    bus_write(32'h0, 32'hF0);
    bus_write(32'h0, 32'h12);
    wait_tx_low(10);
    repeat (17) @(negedge clk);
    check_eq("pre_rst_tx", 32'(tx), 32'd0);
    #1 rst_n = 1'b0;
    #1 check_eq("async_rst_tx", 32'(tx), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus_read(32'h4, r);  check_eq("post_rst_status", r, 32'h04 | ST_PAR);
    bus_read(32'h8, r);  check_eq("post_rst_baud", r, 32'd434);
    lows = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check_eq("no_residual", 32'(lows), 32'd0);
    check_eq("post_rst_irq", 32'(irq_empty), 32'd1);

`ifdef UART_TX_PARITY_EN
    // Parity frames at divisor 4
    bus_write(32'h8, 32'd4);
    bus_write(32'h0, 32'h07);
    wait_tx_low(10);
    rx_frame(4, 8'h07);
    check_eq("p07_irq", 32'(irq_empty), 32'd1);
    bus_write(32'h0, 32'h03);
    wait_tx_low(10);
    rx_frame(4, 8'h03);
    check_eq("p03_irq", 32'(irq_empty), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
